ssd_scan_controller: RTL and testbench

Display back-end for the single-cycle processor board top. It takes the 16-bit value the processor selects for display (the PC in run mode, or a register-file word in inspect mode) and drives the four-digit seven-segment display. It combines the clock-enable generator, digit-scan state machine, anti-ghosting blank interval, hex decode, optional leading-zero blanking and frame-synchronous value snapshot into one block on the fast clock. Because it uses clock enables instead of derived clocks, it removes the slow-clock display path.

---
 rtl/ssd_scan_controller.sv | 141 ++++++++++++++
 tb/tb_ssd_scan_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_controller.sv
// Four-digit seven-segment scan controller on a single fast clock: tick enable,
// blank/on digit scan, hex decode, leading-zero blanking and frame-synchronous value snapshot.
module ssd_scan_controller #(
  parameter int TICK_DIV = 10000,
  parameter int ON_TICKS = 3
) (
  input  logic        clkFast,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  input  logic        blank_lz,
  output logic [6:0]  Cathode,
  output logic [3:0]  AN,
  output logic        frame_done,
  output logic [15:0] shown_value
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = (ON_TICKS > 1) ? $clog2(ON_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(ON_TICKS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  logic [TW-1:0] tick_count;
  logic          tick;
  logic [0:0]    state;
  logic [1:0]    digit;
  logic [PW-1:0] phase;
  logic [15:0]   pending_value;
  logic          pending_flag;
  logic          boundary;
  logic [3:0]    nibble;
  logic [6:0]    seg;
  logic          dark;

  assign tick       = (tick_count == TICK_LAST);
  assign boundary   = tick && (state == ST_ON) && (digit == 2'd0) && (phase == PHASE_LAST);
  assign frame_done = boundary;

  always_comb begin
    nibble = 4'h0;
    dark   = 1'b0;
    case (digit)
      2'd3: begin
        nibble = shown_value[15:12];
        dark   = blank_lz && (shown_value[15:12] == 4'h0);
      end
      2'd2: begin
        nibble = shown_value[11:8];
        dark   = blank_lz && (shown_value[15:8] == 8'h00);
      end
      2'd1: begin
        nibble = shown_value[7:4];
        dark   = blank_lz && (shown_value[15:4] == 12'h000);
      end
      default: begin
        nibble = shown_value[3:0];
        dark   = 1'b0;
      end
    endcase
  end

  // Active-low segments, bit order gfedcba.
  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

  always_ff @(posedge clkFast) begin
    if (reset || tick) begin
      tick_count <= '0;
    end else begin
      tick_count <= tick_count + 1'b1;
    end
  end

  // Outputs are loaded on the BLANK->ON edge and held through the whole ON phase.
  always_ff @(posedge clkFast) begin
    if (reset) begin
      state   <= ST_BLANK;
      digit   <= 2'd3;
      phase   <= '0;
      AN      <= 4'b1111;
      Cathode <= 7'b1111111;
    end else if (tick) begin
      if (state == ST_BLANK) begin
        state   <= ST_ON;
        phase   <= '0;
        AN      <= ~(4'b0001 << digit);
        Cathode <= dark ? 7'b1111111 : seg;
      end else if (phase == PHASE_LAST) begin
        state   <= ST_BLANK;
        phase   <= '0;
        digit   <= digit - 2'd1;
        AN      <= 4'b1111;
        Cathode <= 7'b1111111;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  // A strobe on the boundary cycle bypasses the pending register.
  always_ff @(posedge clkFast) begin
    if (reset) begin
      shown_value   <= 16'h0000;
      pending_value <= 16'h0000;
      pending_flag  <= 1'b0;
    end else if (boundary) begin
      if (value_valid) begin
        shown_value <= value_in;
      end else if (pending_flag) begin
        shown_value <= pending_value;
      end
      pending_flag <= 1'b0;
    end else if (value_valid) begin
      pending_value <= value_in;
      pending_flag  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with TICK_DIV=4, ON_TICKS=2 (12 ticks = 48 cycles per frame).
module tb_ssd_scan_controller;

  logic        clkFast;
  logic        reset;
  logic [15:0] value_in;
  logic        value_valid;
  logic        blank_lz;
  logic [6:0]  Cathode;
  logic [3:0]  AN;
  logic        frame_done;
  logic [15:0] shown_value;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ssd_scan_controller #(.TICK_DIV(4), .ON_TICKS(2)) dut (
    .clkFast     (clkFast),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .blank_lz    (blank_lz),
    .Cathode     (Cathode),
    .AN          (AN),
    .frame_done  (frame_done),
    .shown_value (shown_value)
  );

  initial clkFast = 1'b0;
  always #5 clkFast = ~clkFast;

  // cyc is the cycle index since the last reset edge; sampling happens on the falling edge.
  task automatic goto_cycle(input int target);
    while (cyc < target) begin
      @(negedge clkFast);
      cyc++;
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    value_in    = v;
    value_valid = 1'b1;
    goto_cycle(cyc + 1);
    value_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; value_in = 16'h0000; value_valid = 1'b0; blank_lz = 1'b0;
    repeat (3) @(posedge clkFast);
    #1 reset = 1'b0;
    @(negedge clkFast);
    cyc = 0;
    checks++;
    if (AN !== 4'b1111 || Cathode !== 7'b1111111 || frame_done !== 1'b0 || shown_value !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_state: AN=%b Cathode=%b frame_done=%b shown=%h expected 1111 1111111 0 0000", AN, Cathode, frame_done, shown_value);
    end
    goto_cycle(3);
    checks++;
    if (AN !== 4'b1111) begin
      errors++; $display("[TB] FAIL first_blank: AN=%b expected 1111", AN);
    end
    goto_cycle(4);
    checks++;
    if (AN !== 4'b0111 || Cathode !== 7'b1000000) begin
      errors++; $display("[TB] FAIL first_on: AN=%b Cathode=%b expected 0111 1000000", AN, Cathode);
    end
    goto_cycle(46);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("[TB] FAIL frame_done_early: got %b expected 0", frame_done);
    end
    goto_cycle(47);
    checks++;
    if (frame_done !== 1'b1 || AN !== 4'b1110) begin
      errors++; $display("[TB] FAIL frame_done_47: frame_done=%b AN=%b expected 1 1110", frame_done, AN);
    end
    goto_cycle(48);
    checks++;
    if (frame_done !== 1'b0 || AN !== 4'b1111) begin
      errors++; $display("[TB] FAIL after_frame: frame_done=%b AN=%b expected 0 1111", frame_done, AN);
    end
  endtask

  task automatic test_decode;
    logic [3:0] exp_an [4];
    logic [6:0] exp_cat [4];
    exp_an  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    exp_cat = '{7'b1111001, 7'b0001000, 7'b0000000, 7'b0001110};
    goto_cycle(50);
    strobe(16'h1A8F);
    goto_cycle(95);
    checks++;
    if (shown_value !== 16'h0000) begin
      errors++; $display("[TB] FAIL decode_hold: shown=%h expected 0000", shown_value);
    end
    goto_cycle(96);
    checks++;
    if (shown_value !== 16'h1A8F) begin
      errors++; $display("[TB] FAIL decode_load: shown=%h expected 1a8f", shown_value);
    end
    for (int k = 0; k < 4; k++) begin
      goto_cycle(96 + 12 * k + 1);
      checks++;
      if (AN !== 4'b1111 || Cathode !== 7'b1111111) begin
        errors++; $display("[TB] FAIL decode_blank%0d: AN=%b Cathode=%b expected 1111 1111111", k, AN, Cathode);
      end
      goto_cycle(96 + 12 * k + 5);
      checks++;
      if (AN !== exp_an[k] || Cathode !== exp_cat[k]) begin
        errors++; $display("[TB] FAIL decode_on%0d: AN=%b Cathode=%b expected %b %b", k, AN, Cathode, exp_an[k], exp_cat[k]);
      end
    end
  endtask

  task automatic test_lz;
    logic [6:0] exp_cat [4];
    goto_cycle(144);
    blank_lz = 1'b1;
    strobe(16'h0005);
    exp_cat = '{7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010};
    for (int k = 0; k < 4; k++) begin
      goto_cycle(192 + 12 * k + 5);
      checks++;
      if (Cathode !== exp_cat[k]) begin
        errors++; $display("[TB] FAIL lz_0005_d%0d: Cathode=%b expected %b", 3 - k, Cathode, exp_cat[k]);
      end
    end
    checks++;
    if (AN !== 4'b1110) begin
      errors++; $display("[TB] FAIL lz_0005_an0: AN=%b expected 1110", AN);
    end
    goto_cycle(240);
    strobe(16'h0000);
    exp_cat = '{7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
    for (int k = 0; k < 4; k++) begin
      goto_cycle(288 + 12 * k + 5);
      checks++;
      if (Cathode !== exp_cat[k]) begin
        errors++; $display("[TB] FAIL lz_0000_d%0d: Cathode=%b expected %b", 3 - k, Cathode, exp_cat[k]);
      end
    end
    goto_cycle(336);
    strobe(16'h0105);
    exp_cat = '{7'b1111111, 7'b1111001, 7'b1000000, 7'b0010010};
    for (int k = 0; k < 4; k++) begin
      goto_cycle(384 + 12 * k + 5);
      checks++;
      if (Cathode !== exp_cat[k]) begin
        errors++; $display("[TB] FAIL lz_0105_d%0d: Cathode=%b expected %b", 3 - k, Cathode, exp_cat[k]);
      end
    end
    goto_cycle(432);
    blank_lz = 1'b0;
  endtask

  task automatic test_last_wins;
    goto_cycle(440);
    strobe(16'h1111);
    goto_cycle(460);
    strobe(16'h2222);
    goto_cycle(479);
    checks++;
    if (shown_value !== 16'h0105 || frame_done !== 1'b1) begin
      errors++; $display("[TB] FAIL last_wins_hold: shown=%h frame_done=%b expected 0105 1", shown_value, frame_done);
    end
    goto_cycle(480);
    checks++;
    if (shown_value !== 16'h2222) begin
      errors++; $display("[TB] FAIL last_wins_load: shown=%h expected 2222", shown_value);
    end
    goto_cycle(485);
    checks++;
    if (AN !== 4'b0111 || Cathode !== 7'b0100100) begin
      errors++; $display("[TB] FAIL last_wins_digit: AN=%b Cathode=%b expected 0111 0100100", AN, Cathode);
    end
  endtask

  task automatic test_back_to_back;
    goto_cycle(510);
    strobe(16'h4444);
    goto_cycle(527);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("[TB] FAIL boundary_pulse: frame_done=%b expected 1", frame_done);
    end
    strobe(16'h3333);
    checks++;
    if (shown_value !== 16'h3333) begin
      errors++; $display("[TB] FAIL boundary_strobe: shown=%h expected 3333", shown_value);
    end
    goto_cycle(533);
    checks++;
    if (Cathode !== 7'b0110000) begin
      errors++; $display("[TB] FAIL boundary_digit: Cathode=%b expected 0110000", Cathode);
    end
    goto_cycle(576);
    checks++;
    if (shown_value !== 16'h3333) begin
      errors++; $display("[TB] FAIL pending_cleared: shown=%h expected 3333", shown_value);
    end
  endtask

  task automatic test_reset_mid;
    goto_cycle(580);
    strobe(16'h5555);
    goto_cycle(605);
    checks++;
    if (AN !== 4'b1101) begin
      errors++; $display("[TB] FAIL mid_digit1: AN=%b expected 1101", AN);
    end
    reset = 1'b1;
    goto_cycle(606);
    reset = 1'b0;
    checks++;
    if (AN !== 4'b1111 || Cathode !== 7'b1111111 || shown_value !== 16'h0000 || frame_done !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset: AN=%b Cathode=%b shown=%h frame_done=%b expected 1111 1111111 0000 0", AN, Cathode, shown_value, frame_done);
    end
    goto_cycle(610);
    checks++;
    if (AN !== 4'b0111 || Cathode !== 7'b1000000) begin
      errors++; $display("[TB] FAIL mid_restart: AN=%b Cathode=%b expected 0111 1000000", AN, Cathode);
    end
    goto_cycle(653);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_frame_done: frame_done=%b expected 1", frame_done);
    end
    goto_cycle(654);
    checks++;
    if (shown_value !== 16'h0000) begin
      errors++; $display("[TB] FAIL mid_discard: shown=%h expected 0000", shown_value);
    end
    goto_cycle(658);
    checks++;
    if (AN !== 4'b0111 || Cathode !== 7'b1000000) begin
      errors++; $display("[TB] FAIL mid_discard_digit: AN=%b Cathode=%b expected 0111 1000000", AN, Cathode);
    end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_lz;
    test_last_wins;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
